cdb_arbiter: RTL and testbench
==============================

# cdb_arbiter

Writeback-side transmitter for the common data bus. Drains result streams from the functional-unit issue queues (ALU, jump, etc.) into per-source buffers, then broadcasts up to `CDB_COUNT` results per cycle on the registered CDB ports. The issue queues consume these ports as their CDB forwarding inputs (`cdb_data_i` / `cdb_reg_id_i` / `cdb_valid_i`), and so does the ROB. Each source sees an always-registered `ready` as its downstream "FIFO ready".

## Interface
- `SRC_COUNT`, 4, number of result-producing issue queues
- `CDB_COUNT`, 2, CDB broadcast slots per cycle (1..SRC_COUNT)
- `FIFO_DEPTH`, 2, entries per source buffer; power of two, ≥2
- `clk`  in  1  single clock, all state on rising edge
- `rst`  in  1  synchronous, active-high reset
- `flush`  in  1  pipeline flush; discards all buffered results
- `src_valid_i`  in  SRC_COUNT  source i presents a result
- `src_data_i`  in  SRC_COUNT×word_t  result value
- `src_reg_id_i`  in  SRC_COUNT×rob_id_t  destination ROB id
- `src_ready_o`  out  SRC_COUNT  buffer i can accept this cycle
- `cdb_data_o`  out  CDB_COUNT×word_t  broadcast value
- `cdb_reg_id_o`  out  CDB_COUNT×rob_id_t  broadcast ROB id
- `cdb_valid_o`  out  CDB_COUNT  slot valid

## Operation
- Push: an entry enters buffer i when `src_valid_i[i] && src_ready_o[i]` and neither `rst` nor `flush` is asserted.
- `src_ready_o[i] = (count_q[i] != FIFO_DEPTH)`, from registered count only.
- A full buffer that pops in the same cycle still shows ready=0. There is no same-cycle bypass.
- Arbitration is combinational over non-empty buffers in round-robin order starting at `rr_ptr_q`.
  - Slot 0 takes the first non-empty source at or after `rr_ptr_q`, wrapping modulo SRC_COUNT.
  - Slot k takes the next non-empty source after slot k-1's source.
  - Each source can be granted at most once per cycle, so there is at most one pop per buffer.
- Granted buffers pop their head. The head's {data, reg_id} is registered into slot k.
  - `cdb_valid_o[k]` = 1 if slot k was granted, else 0.
  - Data and reg_id of an invalid slot are 0.
- `rr_ptr_q` moves to (last granted source + 1) mod SRC_COUNT. With no grant it holds.
- Per-source ordering is preserved (FIFO). There is no ordering guarantee across sources.
- Buffers are circular: read/write pointers of log2(FIFO_DEPTH) bits wrap naturally. Count is log2(FIFO_DEPTH)+1 bits.
- Flush or rst, same cycle behaviour:
  - All buffers are cleared: pointers and counts go to 0.
  - `rr_ptr_q` goes to 0.
  - All `cdb_*_o` go to 0 on the next edge.
  - Pushes in that cycle are dropped.
  - Arbitration in that cycle produces no output.
- `rst` and `flush` act identically. Reset mid-stream loses all in-flight results.

## Timing
- Reset values: `cdb_valid_o`=0, `cdb_data_o`=0, `cdb_reg_id_o`=0, `src_ready_o`=all 1 (count 0), `rr_ptr_q`=0.
- Latency: a push accepted at edge t is arbitrated in cycle t+1. At earliest it appears with `cdb_valid_o` high in cycle t+2, i.e. valid for one cycle after the second edge.
- Throughput: up to CDB_COUNT results per cycle total, and up to 1 per source per cycle.
- `src_ready_o` reflects a pop one cycle late. A source sustaining 1/cycle with no competition alternates accept/stall only if FIFO_DEPTH=1 (disallowed). With depth ≥2 it is stall-free.
- CDB outputs are held for exactly one cycle. There is no backpressure from CDB consumers.

## Structure
- Shared package, next to the existing structure header:
  - `cdb_entry_t` struct {word_t data; rob_id_t reg_id}.
  - `word_t` and `rob_id_t` are reused.
- Sub-module `cdb_src_fifo`, one instance per source:
  - Parameter FIFO_DEPTH.
  - Ports: push, entry in, pop, head out, empty, ready, flush, clk, rst.
- The top level holds the round-robin pointer, the grant logic (loop over CDB_COUNT slots), and the output registers.

## Test plan
- Reset then idle → `src_ready_o`=4'b1111, `cdb_valid_o`=2'b00, all data/reg_id 0 for 5 cycles.
- Single push: src2 with data 0x0000_1234, reg 5 at edge t → cycle t+2 shows `cdb_valid_o`=2'b01, slot0 data 0x1234, reg 5. Next cycle it is 2'b00 and `rr_ptr_q`=3.
- All four sources push once together (rr_ptr 0):
  - t+2: slot0=src0, slot1=src1.
  - t+3: slot0=src2, slot1=src3.
  - `rr_ptr_q` is then 0.
- Wrap-around: `rr_ptr_q`=3, only src3 and src0 non-empty → slot0=src3, slot1=src0, `rr_ptr_q` becomes 1.
- Saturation: all sources push incrementing values every cycle they are ready, for 50 cycles.
  - `cdb_valid_o`=2'b11 every cycle from t+2 on.
  - Each source's outputs appear strictly in push order, with none lost or duplicated.
  - `src_ready_o` deasserts only when count=2.
- Flush with 2 entries buffered in src1 plus a push on src0 in the flush cycle → next cycle `cdb_valid_o`=0, `src_ready_o`=4'b1111. Neither value ever appears on the CDB.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// Shared types for the common-data-bus writeback path.
package cdb_arbiter_pkg;
  localparam int WORD_W   = 32;
  localparam int ROB_ID_W = 5;

  typedef logic [WORD_W-1:0]   word_t;
  typedef logic [ROB_ID_W-1:0] rob_id_t;

  typedef struct packed {
    word_t   data;
    rob_id_t reg_id;
  } cdb_entry_t;
endpackage

// File: rtl/cdb_src_fifo.sv
// Per-source circular result buffer; ready is derived from the registered count only.
module cdb_src_fifo
  import cdb_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       push,
  input  cdb_entry_t entry,
  input  logic       pop,
  output cdb_entry_t head,
  output logic       empty,
  output logic       ready
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  cdb_entry_t       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             do_push;
  logic             do_pop;

  assign ready   = (count_q != (PTR_W+1)'(FIFO_DEPTH));
  assign empty   = (count_q == '0);
  assign head    = mem[rd_ptr_q];
  assign do_push = push && ready;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (!rst && !flush && do_push) begin
      mem[wr_ptr_q] <= entry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

// File: rtl/cdb_arbiter.sv
// Drains per-source result buffers onto CDB_COUNT registered broadcast slots,
// granting non-empty sources in round-robin order from rr_ptr_q.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int SRC_COUNT  = 4,
  parameter int CDB_COUNT  = 2,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 flush,
  input  logic [SRC_COUNT-1:0]                 src_valid_i,
  input  logic [SRC_COUNT-1:0][WORD_W-1:0]     src_data_i,
  input  logic [SRC_COUNT-1:0][ROB_ID_W-1:0]   src_reg_id_i,
  output logic [SRC_COUNT-1:0]                 src_ready_o,
  output logic [CDB_COUNT-1:0][WORD_W-1:0]     cdb_data_o,
  output logic [CDB_COUNT-1:0][ROB_ID_W-1:0]   cdb_reg_id_o,
  output logic [CDB_COUNT-1:0]                 cdb_valid_o
);
  localparam int SRC_W = (SRC_COUNT > 1) ? $clog2(SRC_COUNT) : 1;

  logic [SRC_W-1:0]     rr_ptr_q;
  logic [SRC_W-1:0]     rr_ptr_d;
  cdb_entry_t           head [SRC_COUNT];
  logic [SRC_COUNT-1:0] empty;
  logic [SRC_COUNT-1:0] pop;
  cdb_entry_t           slot_d [CDB_COUNT];
  logic [CDB_COUNT-1:0] slot_vld_d;

  for (genvar g = 0; g < SRC_COUNT; g++) begin : g_src
    cdb_entry_t push_entry;
    assign push_entry = '{data: src_data_i[g], reg_id: src_reg_id_i[g]};

    cdb_src_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .push  (src_valid_i[g]),
      .entry (push_entry),
      .pop   (pop[g]),
      .head  (head[g]),
      .empty (empty[g]),
      .ready (src_ready_o[g])
    );
  end

  // Each slot searches onward from the previous slot's winner; granted
  // sources are masked so no buffer pops twice in one cycle.
  always_comb begin
    logic [SRC_COUNT-1:0] avail;
    logic [SRC_W-1:0]     idx;
    logic [SRC_W-1:0]     sel;
    logic                 found;
    int                   base;

    avail      = ~empty;
    idx        = '0;
    sel        = '0;
    found      = 1'b0;
    base       = int'(rr_ptr_q);
    pop        = '0;
    slot_vld_d = '0;
    rr_ptr_d   = rr_ptr_q;
    for (int k = 0; k < CDB_COUNT; k++) slot_d[k] = '0;

    for (int k = 0; k < CDB_COUNT; k++) begin
      found = 1'b0;
      sel   = '0;
      for (int j = 0; j < SRC_COUNT; j++) begin
        idx = SRC_W'((base + j) % SRC_COUNT);
        if (!found && avail[idx]) begin
          found = 1'b1;
          sel   = idx;
        end
      end
      if (found) begin
        avail[sel]    = 1'b0;
        pop[sel]      = 1'b1;
        slot_vld_d[k] = 1'b1;
        slot_d[k]     = head[sel];
        base          = (int'(sel) + 1) % SRC_COUNT;
        rr_ptr_d      = SRC_W'(base);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rr_ptr_q     <= '0;
      cdb_valid_o  <= '0;
      cdb_data_o   <= '0;
      cdb_reg_id_o <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      cdb_valid_o <= slot_vld_d;
      for (int k = 0; k < CDB_COUNT; k++) begin
        cdb_data_o[k]   <= slot_d[k].data;
        cdb_reg_id_o[k] <= slot_d[k].reg_id;
      end
    end
  end
endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: queue-based reference model plus directed literal checks.
module tb_cdb_arbiter;
  localparam int SRC   = 4;
  localparam int CDB   = 2;
  localparam int DEPTH = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  flush;
  logic [SRC-1:0]        src_valid;
  logic [SRC-1:0][31:0]  src_data;
  logic [SRC-1:0][4:0]   src_reg;
  logic [SRC-1:0]        src_ready;
  logic [CDB-1:0][31:0]  cdb_data;
  logic [CDB-1:0][4:0]   cdb_reg;
  logic [CDB-1:0]        cdb_valid;

  int checks = 0;
  int errors = 0;

  cdb_arbiter #(.SRC_COUNT(SRC), .CDB_COUNT(CDB), .FIFO_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .src_valid_i  (src_valid),
    .src_data_i   (src_data),
    .src_reg_id_i (src_reg),
    .src_ready_o  (src_ready),
    .cdb_data_o   (cdb_data),
    .cdb_reg_id_o (cdb_reg),
    .cdb_valid_o  (cdb_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: per-source queues; each cycle the first CDB non-empty
  // sources in rotation order from the pointer each deliver their oldest entry.
  typedef struct { logic [31:0] d; logic [4:0] r; } ent_t;
  ent_t           q [SRC][$];
  logic [CDB-1:0] e_valid;
  logic [31:0]    e_data [CDB];
  logic [4:0]     e_reg [CDB];
  logic [SRC-1:0] e_ready;
  int             m_rr = 0;
  bit             m_ok = 0;

  always @(posedge clk) begin
    logic [SRC-1:0] rdy;
    int n, last, s;
    for (int i = 0; i < SRC; i++) rdy[i] = (q[i].size() != DEPTH);
    e_valid = '0;
    for (int k = 0; k < CDB; k++) begin
      e_data[k] = '0;
      e_reg[k]  = '0;
    end
    if (rst || flush) begin
      for (int i = 0; i < SRC; i++) q[i].delete();
      m_rr = 0;
    end else begin
      n = 0;
      last = -1;
      for (int j = 0; j < SRC; j++) begin
        s = (m_rr + j) % SRC;
        if (n < CDB && q[s].size() > 0) begin
          e_valid[n] = 1'b1;
          e_data[n]  = q[s][0].d;
          e_reg[n]   = q[s][0].r;
          void'(q[s].pop_front());
          n++;
          last = s;
        end
      end
      if (last >= 0) m_rr = (last + 1) % SRC;
      for (int i = 0; i < SRC; i++)
        if (src_valid[i] && rdy[i]) q[i].push_back('{d: src_data[i], r: src_reg[i]});
    end
    for (int i = 0; i < SRC; i++) e_ready[i] = (q[i].size() != DEPTH);
    m_ok = 1;
  end

  always @(negedge clk) begin
    if (m_ok) begin
      chk("cdb_valid", 64'(cdb_valid), 64'(e_valid));
      for (int k = 0; k < CDB; k++) begin
        chk("cdb_data", 64'(cdb_data[k]), 64'(e_data[k]));
        chk("cdb_reg_id", 64'(cdb_reg[k]), 64'(e_reg[k]));
      end
      chk("src_ready", 64'(src_ready), 64'(e_ready));
      chk("rr_ptr", 64'(dut.rr_ptr_q), 64'(m_rr));
    end
  end

  task automatic idle();
    src_valid = '0;
    src_data  = '0;
    src_reg   = '0;
    flush     = 1'b0;
    rst       = 1'b0;
  endtask

  initial begin
    logic [SRC-1:0] rdy_drv;
    int seq [SRC];

    idle();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // reset then idle
    repeat (5) begin
      @(negedge clk);
      chk("idle_ready", 64'(src_ready), 64'hF);
      chk("idle_valid", 64'(cdb_valid), 64'h0);
      chk("idle_data", 64'({cdb_data[1], cdb_data[0]}), 64'h0);
      chk("idle_reg", 64'({cdb_reg[1], cdb_reg[0]}), 64'h0);
    end

    // all four sources at once, pointer at 0
    for (int i = 0; i < SRC; i++) begin
      src_data[i] = 32'h100 + 32'(i);
      src_reg[i]  = 5'(i + 8);
    end
    src_valid = 4'b1111;
    @(negedge clk); idle();
    chk("all4_t1_valid", 64'(cdb_valid), 64'h0);
    @(negedge clk);
    chk("all4_t2_valid", 64'(cdb_valid), 64'h3);
    chk("all4_t2_s0", 64'(cdb_data[0]), 64'h100);
    chk("all4_t2_s1", 64'(cdb_data[1]), 64'h101);
    @(negedge clk);
    chk("all4_t3_valid", 64'(cdb_valid), 64'h3);
    chk("all4_t3_s0", 64'(cdb_data[0]), 64'h102);
    chk("all4_t3_s1", 64'(cdb_data[1]), 64'h103);
    chk("all4_t3_r1", 64'(cdb_reg[1]), 64'd11);
    chk("all4_rr", 64'(dut.rr_ptr_q), 64'd0);

    // single push on src2
    @(negedge clk);
    src_valid[2] = 1'b1; src_data[2] = 32'h0000_1234; src_reg[2] = 5'd5;
    @(negedge clk); idle();
    @(negedge clk);
    chk("single_valid", 64'(cdb_valid), 64'h1);
    chk("single_data", 64'(cdb_data[0]), 64'h1234);
    chk("single_reg", 64'(cdb_reg[0]), 64'd5);
    @(negedge clk);
    chk("single_after", 64'(cdb_valid), 64'h0);
    chk("single_rr", 64'(dut.rr_ptr_q), 64'd3);

    // wrap-around: src3 and src0 with pointer at 3
    src_valid = 4'b1001; src_data[0] = 32'hA0; src_data[3] = 32'hA3;
    @(negedge clk); idle();
    @(negedge clk);
    chk("wrap_valid", 64'(cdb_valid), 64'h3);
    chk("wrap_s0", 64'(cdb_data[0]), 64'hA3);
    chk("wrap_s1", 64'(cdb_data[1]), 64'hA0);
    chk("wrap_rr", 64'(dut.rr_ptr_q), 64'd1);

    // move pointer to 2 via a lone src1 result
    @(negedge clk);
    src_valid[1] = 1'b1; src_data[1] = 32'h55;
    @(negedge clk); idle();
    @(negedge clk);
    chk("p2_data", 64'(cdb_data[0]), 64'h55);
    @(negedge clk);
    chk("p2_rr", 64'(dut.rr_ptr_q), 64'd2);

    // flush with two entries parked in src1 plus a src0 push in the flush cycle
    src_valid = 4'b1110;
    src_data[1] = 32'hD1A; src_data[2] = 32'hD2; src_data[3] = 32'hD3;
    @(negedge clk); idle();
    src_valid[1] = 1'b1; src_data[1] = 32'hD1B;
    @(negedge clk); idle();
    chk("fl_pre_valid", 64'(cdb_valid), 64'h3);
    chk("fl_pre_s0", 64'(cdb_data[0]), 64'hD2);
    chk("fl_pre_s1", 64'(cdb_data[1]), 64'hD3);
    chk("fl_pre_ready", 64'(src_ready), 64'b1101);
    flush = 1'b1;
    src_valid[0] = 1'b1; src_data[0] = 32'hD0;
    @(negedge clk); idle();
    chk("fl_valid", 64'(cdb_valid), 64'h0);
    chk("fl_ready", 64'(src_ready), 64'hF);
    repeat (3) begin
      @(negedge clk);
      chk("fl_quiet", 64'(cdb_valid), 64'h0);
    end

    // randomized traffic with occasional flush and reset
    repeat (400) begin
      for (int i = 0; i < SRC; i++) begin
        src_valid[i] = ($urandom_range(0, 99) < 45);
        src_data[i]  = $urandom;
        src_reg[i]   = 5'($urandom);
      end
      flush = ($urandom_range(0, 39) == 0);
      rst   = ($urandom_range(0, 99) == 0);
      @(negedge clk);
    end
    idle();
    repeat (10) @(negedge clk);

    // saturation: every source offers a fresh value each cycle
    for (int i = 0; i < SRC; i++) seq[i] = 0;
    for (int c = 0; c <= 50; c++) begin
      if (c >= 2) chk("sat_valid", 64'(cdb_valid), 64'h3);
      if (c > 0)
        for (int i = 0; i < SRC; i++) if (rdy_drv[i]) seq[i]++;
      rdy_drv   = src_ready;
      src_valid = 4'b1111;
      for (int i = 0; i < SRC; i++) begin
        src_data[i] = {8'(i), 24'(seq[i])};
        src_reg[i]  = 5'(seq[i]);
      end
      @(negedge clk);
    end
    idle();
    repeat (10) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
